mlp_frame_loader: RTL and testbench

- Host-side driver for the forward-pass classifier wrapper. It is the initiator of that wrapper's start/done protocol.
- Accepts a serial pixel stream over a valid/ready byte interface and packs VECTOR_SIZE pixels into the flat vector.
- Pulses start, waits for done, captures predict_digit and presents it on a valid/ready result port.
- Sits between the pixel source (UART/camera front end) and the classifier wrapper.

---
 rtl/mlp_frame_loader.sv | 147 ++++++++++++++
 tb/tb_mlp_frame_loader.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mlp_frame_loader.sv
//------------------------------------------------------------------------------
// Module   : mlp_frame_loader
// Brief    : Packs a pixel stream into a frame, runs the classifier start/done
//            handshake and presents the prediction on a valid/ready port.
//            Optional WAIT_DONE watchdog: define MLP_LOADER_WATCHDOG_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mlp_frame_loader #(
  parameter int DATA_WIDTH     = 8,
  parameter int VECTOR_SIZE    = 196,
  parameter int CNT_W          = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [DATA_WIDTH-1:0]             pix_data,
  input  logic                              pix_valid,
  output logic                              pix_ready,
  output logic [DATA_WIDTH*VECTOR_SIZE-1:0] pixels_out,
  output logic                              clf_start,
  output logic                              clf_en,
  input  logic                              clf_done,
  input  logic [3:0]                        clf_digit,
  output logic [3:0]                        result_digit,
  output logic                              result_valid,
  input  logic                              result_ready,
  output logic                              busy,
  output logic                              timeout_err
);

  localparam logic [1:0] c_st_load = 2'd0;
  localparam logic [1:0] c_st_fire = 2'd1;
  localparam logic [1:0] c_st_wait = 2'd2;
  localparam logic [1:0] c_st_hold = 2'd3;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_pix_cnt;
  logic [3:0]       r_result_digit;
  logic             r_result_valid;
  logic             w_accept;
  logic             w_last;
  logic             w_timeout;

  assign w_accept = pix_valid && (r_state == c_st_load);
  assign w_last   = (r_pix_cnt == CNT_W'(VECTOR_SIZE - 1));

`ifdef MLP_LOADER_WATCHDOG_EN
  localparam int c_wd_w = $clog2(TIMEOUT_CYCLES + 1);

  logic [c_wd_w-1:0] r_wd_cnt;
  logic              r_timeout_err;

  // A done in the same cycle as expiry still wins over the timeout.
  assign w_timeout = (r_state == c_st_wait) && !clf_done &&
                     (r_wd_cnt == c_wd_w'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wd_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state == c_st_fire) begin
        r_wd_cnt <= '0;
      end else if (r_state == c_st_wait) begin
        r_wd_cnt <= r_wd_cnt + c_wd_w'(1);
      end
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign w_timeout   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= c_st_load;
      r_pix_cnt      <= '0;
      r_result_digit <= 4'h0;
      r_result_valid <= 1'b0;
    end else begin
      case (r_state)
        c_st_load: begin
          if (w_accept) begin
            if (w_last) begin
              r_pix_cnt <= '0;
              r_state   <= c_st_fire;
            end else begin
              r_pix_cnt <= r_pix_cnt + CNT_W'(1);
            end
          end
        end
        c_st_fire: begin
          r_state <= c_st_wait;
        end
        c_st_wait: begin
          if (clf_done) begin
            r_result_digit <= clf_digit;
            r_result_valid <= 1'b1;
            r_state        <= c_st_hold;
          end else if (w_timeout) begin
            r_result_digit <= 4'hF;
            r_result_valid <= 1'b1;
            r_state        <= c_st_hold;
          end
        end
        default: begin
          if (result_ready) begin
            r_result_valid <= 1'b0;
            r_state        <= c_st_load;
          end
        end
      endcase
    end
  end

  // One register per slot; slot 0 (first pixel) sits in the MSBs.
  for (genvar g = 0; g < VECTOR_SIZE; g++) begin : g_slot
    logic [DATA_WIDTH-1:0] r_pix;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_pix <= '0;
      end else if (w_accept && (r_pix_cnt == CNT_W'(g))) begin
        r_pix <= pix_data;
      end
    end

    assign pixels_out[DATA_WIDTH*(VECTOR_SIZE-g)-1 -: DATA_WIDTH] = r_pix;
  end

  assign pix_ready    = (r_state == c_st_load);
  assign clf_start    = (r_state == c_st_fire);
  assign clf_en       = reset_n;
  assign result_digit = r_result_digit;
  assign result_valid = r_result_valid;
  assign busy         = !((r_state == c_st_load) && (r_pix_cnt == '0));

endmodule

`default_nettype wire

// File: tb/tb_mlp_frame_loader.sv
//------------------------------------------------------------------------------
// Module   : tb_mlp_frame_loader
// Brief    : Randomized self-checking bench for mlp_frame_loader against a
//            frame/handshake model. Define MLP_LOADER_WATCHDOG_EN for timeout.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mlp_frame_loader;

  localparam int DW = 8;
  localparam int VS = 196;
  localparam int CW = 8;
  localparam int TO = 20;

  logic             clk;
  logic             reset_n;
  logic [DW-1:0]    pix_data;
  logic             pix_valid;
  logic             pix_ready;
  logic [DW*VS-1:0] pixels_out;
  logic             clf_start;
  logic             clf_en;
  logic             clf_done;
  logic [3:0]       clf_digit;
  logic [3:0]       result_digit;
  logic             result_valid;
  logic             result_ready;
  logic             busy;
  logic             timeout_err;

  mlp_frame_loader #(
    .DATA_WIDTH     (DW),
    .VECTOR_SIZE    (VS),
    .CNT_W          (CW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pix_data     (pix_data),
    .pix_valid    (pix_valid),
    .pix_ready    (pix_ready),
    .pixels_out   (pixels_out),
    .clf_start    (clf_start),
    .clf_en       (clf_en),
    .clf_done     (clf_done),
    .clf_digit    (clf_digit),
    .result_digit (result_digit),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the frame as a byte array plus the vector the loader must hold.
  logic [DW-1:0]    frame_m [VS];
  logic [DW*VS-1:0] held_vec;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW*VS-1:0] pack_frame();
    logic [DW*VS-1:0] v;
    v = '0;
    for (int k = 0; k < VS; k++) v[DW*(VS-k)-1 -: DW] = frame_m[k];
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    #2;
    chk("rst_pix_ready", pix_ready, 1);
    chk("rst_clf_en", clf_en, 0);
    chk("rst_clf_start", clf_start, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_result_digit", result_digit, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_pixels_zero", pixels_out == '0, 1);
    held_vec = '0;
    step();
    reset_n = 1'b1;
    #1;
    chk("post_rst_clf_en", clf_en, 1);
  endtask

  // Stream n pixels; a full frame ends with the start-pulse checks.
  task automatic send_frame(input int n, input int gap_pct, input bit spurious, input bit ramp);
    int k = 0;
    int cyc = 0;
    bit v;
    logic [DW-1:0] d;
    while (k < n) begin
      if (k == 0 && cyc == 0) begin
        chk("idle_busy", busy, 0);
        chk("frame_held", pixels_out === held_vec, 1);
      end
      v = ($urandom_range(99) >= gap_pct);
      d = ramp ? DW'(k) : DW'($urandom);
      pix_valid = v;
      pix_data  = d;
      clf_done  = spurious && (cyc == 10);
      clf_digit = 4'h7;
      chk("load_ready", pix_ready, 1);
      chk("load_no_start", clf_start, 0);
      chk("load_no_result", result_valid, 0);
      step();
      if (v) begin
        frame_m[k] = d;
        k++;
      end
      cyc++;
    end
    pix_valid = 1'b0;
    clf_done  = 1'b0;
    if (n == VS) begin
      chk("fire_start", clf_start, 1);
      chk("fire_ready", pix_ready, 0);
      chk("fire_busy", busy, 1);
      chk("fire_frame", pixels_out === pack_frame(), 1);
    end
  endtask

  // Called right after the start pulse appears; pix_valid stays high to prove it is ignored.
  task automatic finish_frame(input int done_delay, input logic [3:0] digit, input int ready_delay);
    logic [DW*VS-1:0] exp_vec;
    exp_vec   = pack_frame();
    pix_valid = 1'b1;
    pix_data  = DW'($urandom);
    step();
    chk("start_one_cycle", clf_start, 0);
    for (int i = 0; i < done_delay; i++) begin
      result_ready = (i == 2);
      chk("wait_no_result", result_valid, 0);
      chk("wait_ready", pix_ready, 0);
      step();
    end
    result_ready = 1'b0;
    clf_done  = 1'b1;
    clf_digit = digit;
    step();
    clf_done  = 1'b0;
    clf_digit = 4'($urandom);
    chk("result_valid", result_valid, 1);
    chk("result_digit", result_digit, digit);
    chk("hold_ready", pix_ready, 0);
    chk("hold_frame", pixels_out === exp_vec, 1);
    chk("timeout_err_clear", timeout_err, 0);
    for (int i = 0; i < ready_delay; i++) begin
      step();
      chk("hold_valid", result_valid, 1);
      chk("hold_digit", result_digit, digit);
      chk("hold_no_ready", pix_ready, 0);
    end
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    pix_valid    = 1'b0;
    chk("handshake_ready", pix_ready, 1);
    chk("handshake_valid", result_valid, 0);
    chk("handshake_frame", pixels_out === exp_vec, 1);
    held_vec = exp_vec;
  endtask

  initial begin
    reset_n      = 1'b0;
    pix_data     = '0;
    pix_valid    = 1'b0;
    clf_done     = 1'b0;
    clf_digit    = 4'h0;
    result_ready = 1'b0;
    apply_reset();

    // Ramp frame: first pixel in the MSBs, 0xC3 in the LSBs.
    send_frame(VS, 0, 1'b0, 1'b1);
    chk("ramp_msb", pixels_out[DW*VS-1 -: DW], 8'h00);
    chk("ramp_lsb", pixels_out[DW-1:0], 8'hC3);
    finish_frame(49, 4'd3, 10);

    // Back-to-back frame with done already high on the first WAIT_DONE cycle.
    send_frame(VS, 0, 1'b0, 1'b0);
    finish_frame(0, 4'd1, 0);

    // Gappy stream, spurious done in LOAD, out-of-range digit.
    send_frame(VS, 30, 1'b1, 1'b0);
    finish_frame(int'($urandom_range(1, 20)), 4'hC, int'($urandom_range(0, 5)));

    // Reset mid-frame, then a full frame is required.
    send_frame(100, 20, 1'b0, 1'b0);
    apply_reset();
    send_frame(VS, 10, 1'b0, 1'b0);
    finish_frame(5, 4'd9, 2);

    // Reset during WAIT_DONE.
    send_frame(VS, 0, 1'b0, 1'b0);
    step();
    step();
    apply_reset();
    send_frame(VS, 15, 1'b0, 1'b0);
    finish_frame(3, 4'd5, 1);

`ifdef MLP_LOADER_WATCHDOG_EN
    // Never answer: result appears 21 cycles after WAIT_DONE is entered.
    send_frame(VS, 0, 1'b0, 1'b0);
    step();
    for (int i = 0; i < TO; i++) begin
      step();
      chk("wd_no_result", result_valid, 0);
    end
    step();
    chk("wd_result_valid", result_valid, 1);
    chk("wd_result_digit", result_digit, 4'hF);
    chk("wd_timeout_err", timeout_err, 1);
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    chk("wd_back_to_load", pix_ready, 1);
    chk("wd_sticky", timeout_err, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit reached");
  end

endmodule

`default_nettype wire
